// File: rtl/full_adder_pipe.sv
// full_adder_pipe: registered ripple-carry adder, {carry, sum} = x + y + c_in.
// WIDTH identical full-adder cells are chained bit 0 -> MSB. The result and a
// valid flag are registered once, so the latency is exactly one cycle.

// One-bit combinational full-adder cell.
module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

module full_adder_pipe #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid
);

  // Carry chain: chain_s[0] is the carry in, chain_s[WIDTH] the carry out.
  logic [WIDTH:0]   chain_s;
  logic [WIDTH-1:0] sum_s;

  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic             carry_q;
  logic             carry_d;
  logic             valid_q;
  logic             valid_d;

  assign chain_s[0] = c_in;

  // Plain ripple chain of identical cells; no lookahead on purpose.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a_i (x[i]),
      .b_i (y[i]),
      .c_i (chain_s[i]),
      .s_o (sum_s[i]),
      .c_o (chain_s[i+1])
    );
  end

  // Next-state: capture a new result on valid input, otherwise hold the result.
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    valid_d = 1'b0;
    if (in_valid) begin
      sum_d   = sum_s;
      carry_d = chain_s[WIDTH];
      valid_d = 1'b1;
    end else begin
      sum_d   = sum_q;
      carry_d = carry_q;
      valid_d = 1'b0;
    end
  end

  // Output registers; synchronous reset wins over any operand in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  assign sum       = sum_q;
  assign carry     = carry_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_full_adder_pipe.sv
// Testbench for full_adder_pipe: one WIDTH=1 and one WIDTH=5 instance driven
// side by side. Expected results come from plain integer addition and are
// queued at the clock edge; a monitor pops and compares one cycle later.
module tb_full_adder_pipe;

  logic       clk;
  logic       rst;
  logic       v1, x1, y1, c1;
  logic       v5, c5;
  logic [4:0] x5, y5;
  logic       s1, co1, ov1;
  logic [4:0] s5;
  logic       co5, ov5;

  int n_tests;
  int n_fail;
  bit mon_on;

  // Reference model state
  logic [1:0] q1[$];
  logic [5:0] q5[$];
  bit         ev1, ev5;
  logic [1:0] h1;
  logic [5:0] h5;

  full_adder_pipe #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .x(x1), .y(y1), .c_in(c1),
    .sum(s1), .carry(co1), .out_valid(ov1)
  );

  full_adder_pipe #(.WIDTH(5)) u_dut5 (
    .clk(clk), .rst(rst), .in_valid(v5), .x(x5), .y(y5), .c_in(c5),
    .sum(s5), .carry(co5), .out_valid(ov5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, then update the model at the sampling edge.
  task automatic step(input logic r,
                      input logic a_v, input logic a_x, input logic a_y, input logic a_c,
                      input logic b_v, input logic [4:0] b_x, input logic [4:0] b_y,
                      input logic b_c);
    int r1;
    int r5;
    rst = r;
    v1 = a_v; x1 = a_x; y1 = a_y; c1 = a_c;
    v5 = b_v; x5 = b_x; y5 = b_y; c5 = b_c;
    @(posedge clk);
    r1 = int'(a_x) + int'(a_y) + int'(a_c);
    r5 = int'(b_x) + int'(b_y) + int'(b_c);
    if (r) begin
      ev1 = 1'b0; h1 = 2'd0;
      ev5 = 1'b0; h5 = 6'd0;
    end else begin
      if (a_v) begin
        ev1 = 1'b1; h1 = r1[1:0]; q1.push_back(r1[1:0]);
      end else begin
        ev1 = 1'b0;
      end
      if (b_v) begin
        ev5 = 1'b1; h5 = r5[5:0]; q5.push_back(r5[5:0]);
      end else begin
        ev5 = 1'b0;
      end
    end
    #2;
  endtask

  // Random operands for the instance not under directed test.
  task automatic step_rw5(input logic r, input logic a_v, input logic a_x,
                          input logic a_y, input logic a_c);
    step(r, a_v, a_x, a_y, a_c, 1'($urandom_range(1)), 5'($urandom),
         5'($urandom), 1'($urandom_range(1)));
  endtask

  // Monitor: one cycle after each edge compare valid flags and data.
  always @(posedge clk) begin
    logic [1:0] e1;
    logic [5:0] e5;
    #1;
    if (mon_on) begin
      chk("w1_out_valid", 32'(ov1), 32'(ev1));
      if (ov1) begin
        if (q1.size() == 0) begin
          chk("w1_unexpected_output", 32'd1, 32'd0);
        end else begin
          e1 = q1.pop_front();
          chk("w1_result", 32'({co1, s1}), 32'(e1));
        end
      end else begin
        chk("w1_hold", 32'({co1, s1}), 32'(h1));
      end
      chk("w5_out_valid", 32'(ov5), 32'(ev5));
      if (ov5) begin
        if (q5.size() == 0) begin
          chk("w5_unexpected_output", 32'd1, 32'd0);
        end else begin
          e5 = q5.pop_front();
          chk("w5_result", 32'({co5, s5}), 32'(e5));
        end
      end else begin
        chk("w5_hold", 32'({co5, s5}), 32'(h5));
      end
    end
  end

  initial begin
    logic [2:0] tt;
    n_tests = 0;
    n_fail  = 0;
    ev1 = 1'b0; ev5 = 1'b0; h1 = 2'd0; h5 = 6'd0;
    mon_on = 1'b1;
    rst = 1'b1;
    v1 = 1'b0; x1 = 1'b0; y1 = 1'b0; c1 = 1'b0;
    v5 = 1'b0; x5 = 5'd0; y5 = 5'd0; c5 = 1'b0;
    #1;

    // Reset with valid operands present: all must be dropped
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd31, 5'd31, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd31, 5'd31, 1'b1);

    // Full truth table back to back on the 1-bit cell
    for (int i = 0; i < 8; i++) begin
      tt = 3'(i);
      step_rw5(1'b0, 1'b1, tt[2], tt[1], tt[0]);
    end

    // Hold: load 1+1+0, then toggle inputs with in_valid low
    step_rw5(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'(i), 1'(i + 1), 1'(i), 1'b0, 5'($urandom),
           5'($urandom), 1'($urandom_range(1)));
    end

    // Wide carry chain cases
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b11111, 5'b00000, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b10110, 5'b01101, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b11111, 5'b11111, 1'b1);

    // Reset mid-stream
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 5'd9, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 5'd9, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 5'd3, 1'b1);

    // Random traffic
    for (int i = 0; i < 1000; i++) begin
      step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)),
           1'($urandom_range(1)), 1'($urandom_range(1)),
           1'($urandom_range(1)), 5'($urandom), 5'($urandom),
           1'($urandom_range(1)));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);

    mon_on = 1'b0;
    chk("w1_queue_drained", 32'(q1.size()), 32'd0);
    chk("w5_queue_drained", 32'(q5.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/full_adder_pipe.md
Name: full_adder_pipe

Overview:
- Registered ripple-carry adder built from 1-bit full-adder cells: {carry, sum} = x + y + c_in.
- With the default WIDTH=1 it is a single clocked full adder, the basic cell of the 5-bit array multiplier's partial-product reduction rows.
- Wider instances chain WIDTH cells internally.
- Outputs are registered once, with a valid flag, so multiplier rows can be pipelined.

Parameters:
- WIDTH, 1, operand width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  x, y, c_in are valid this cycle.
- x  input  WIDTH  addend A, unsigned.
- y  input  WIDTH  addend B, unsigned.
- c_in  input  1  carry into bit 0.
- sum  output  WIDTH  registered sum bits.
- carry  output  1  registered carry out of the MSB cell.
- out_valid  output  1  sum/carry hold a new result this cycle.

Behaviour:
- Single clock domain. Reset is synchronous and active-high: sampled only on the rising clk edge.
- Reset values: with rst=1 at an edge, sum=0, carry=0, out_valid=0. rst takes priority over in_valid; an operand presented in a reset cycle is dropped.
- Cell equations, per bit i:
  - s_i = x_i ^ y_i ^ c_i
  - c_(i+1) = (x_i & y_i) | (x_i & c_i) | (y_i & c_i)
  - c_0 = c_in; carry = c_WIDTH.
  - Cells are a generate loop of identical combinational full-adder cells; no carry-lookahead.
- Arithmetic: unsigned. {carry, sum} equals x + y + c_in exactly in WIDTH+1 bits. There is no overflow other than carry; carry=1 means the result is at least 2^WIDTH.
- Latency: exactly 1 cycle.
  - If in_valid=1 at edge N (rst=0), sum and carry show the result after edge N, and out_valid=1 for that cycle.
- Throughput: one operation per cycle. Back-to-back in_valid produces back-to-back out_valid with no bubbles.
- No-valid cycles: if in_valid=0 at an edge (rst=0), out_valid goes to 0 and sum/carry hold their previous values.
- No backpressure: there is no ready signal, and the consumer must accept every out_valid pulse.
- Reset mid-stream: a result registered in the cycle before rst is overwritten with 0. out_valid drops to 0 at the reset edge.
- X-handling: inputs are don't-care when in_valid=0 and must not disturb sum/carry.
- No latches, no combinational path from inputs to outputs, no internal state beyond the output registers.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, x=1, y=1, c_in=1 -> sum=0, carry=0, out_valid=0 throughout.
- Truth table (WIDTH=1): apply (x,y,c_in) = 000, 001, 010, 011, 100, 101, 110, 111 back-to-back with in_valid=1.
  - One cycle later, (sum,carry) = 00, 10, 10, 01, 10, 01, 01, 11 respectively.
  - out_valid stays 1 for all 8 cycles.
- Hold: after x=1, y=1, c_in=0 (sum=0, carry=1), drive in_valid=0 and toggle the inputs for 3 cycles -> sum=0, carry=1 held, out_valid=0.
- Wide carry chain (WIDTH=5): x=5'b11111, y=5'b00000, c_in=1 -> sum=5'b00000, carry=1.
  - Then x=5'b10110, y=5'b01101, c_in=0 -> sum=5'b00011, carry=1.
- Reset mid-stream: in_valid=1, x=1, y=0, c_in=0 at edge N, rst=1 at edge N+1 -> sum=1, out_valid=1 after N; sum=0, out_valid=0 after N+1.
- Random (WIDTH=5): 1000 random x, y, c_in with random in_valid -> {carry, sum} == x+y+c_in one cycle after each valid input; out_valid mirrors in_valid delayed by 1.
